// File: rtl/knight_rider_scanner.sv
// knight_rider_scanner
//   Moving-dot LED scanner with four scan modes, a selectable step rate,
//   PWM brightness and a fading trail in trail mode. All three user inputs
//   are asynchronous push-buttons that are synchronised here.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset (0 = reset)
//   change_rate  async button, each rising edge advances the rate index
//   change_mode  async button, each rising edge advances the scan mode
//   brightness   async button, each rising edge steps the brightness down
//   led          registered LED drive, OUT_WIDTH bits
//   rate_sel     current rate index (0..4)
//   mode_sel     current scan mode (0 bounce, 1 trail, 2 rotate, 3 mirror);
//                this is also the scanner FSM state

module knight_rider_scanner #(
    parameter int OUT_WIDTH = 8,
    parameter int CLK_FREQ  = 6000,
    parameter int CNT_WIDTH = 14,
    parameter int PWM_BITS  = 3,
    parameter int TRAIL_LEN = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 change_rate,
    input  logic                 change_mode,
    input  logic                 brightness,
    output logic [OUT_WIDTH-1:0] led,
    output logic [2:0]           rate_sel,
    output logic [1:0]           mode_sel
);

    localparam int POS_W  = $clog2(OUT_WIDTH);
    localparam int LVL_W  = PWM_BITS + 1;
    localparam int HIST_N = TRAIL_LEN - 1;
    localparam int HIST_D = (HIST_N > 0) ? HIST_N : 1;

    localparam logic [1:0] MODE_BOUNCE = 2'd0;
    localparam logic [1:0] MODE_TRAIL  = 2'd1;
    localparam logic [1:0] MODE_ROTATE = 2'd2;
    localparam logic [1:0] MODE_MIRROR = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [POS_W-1:0] POS_LAST   = POS_W'(OUT_WIDTH - 1);
    localparam logic [POS_W-1:0] POS_HALF   = POS_W'(OUT_WIDTH / 2 - 1);
    localparam logic [LVL_W-1:0] LVL_MAX    = LVL_W'(2 ** PWM_BITS);

    localparam logic [CNT_WIDTH-1:0] RC_0 = CNT_WIDTH'(2 * CLK_FREQ - 1);
    localparam logic [CNT_WIDTH-1:0] RC_1 = CNT_WIDTH'(CLK_FREQ - 1);
    localparam logic [CNT_WIDTH-1:0] RC_2 = CNT_WIDTH'(CLK_FREQ / 2 - 1);
    localparam logic [CNT_WIDTH-1:0] RC_3 = CNT_WIDTH'(CLK_FREQ / 4 - 1);
    localparam logic [CNT_WIDTH-1:0] RC_4 = CNT_WIDTH'(CLK_FREQ / 8 - 1);

    // ------------------------------------------------------------------
    // Button synchronisers. Bit 0 rate, bit 1 mode, bit 2 brightness.
    // Two metastability flops, one edge flop, and a registered one-cycle
    // event pulse; the target register therefore moves on the 4th edge
    // after the pin rises.
    // ------------------------------------------------------------------
    logic [2:0] btn_pins;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] prev;
    logic [2:0] ev;

    assign btn_pins = {brightness, change_mode, change_rate};

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            ev    <= '0;
        end else begin
            sync1 <= btn_pins;
            sync2 <= sync1;
            prev  <= sync2;
            ev    <= sync2 & ~prev;
        end
    end

    logic rate_ev;
    logic mode_ev;
    logic bright_ev;

    assign rate_ev   = ev[0];
    assign mode_ev   = ev[1];
    assign bright_ev = ev[2];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] rate_cnt;
    logic [CNT_WIDTH-1:0] rc_max;
    logic                 step;
    logic [POS_W-1:0]     pos;
    logic                 dir;
    logic [LVL_W-1:0]     bright_lvl;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic [POS_W-1:0]     hist_pos [HIST_D];
    logic [HIST_D-1:0]    hist_vld;

    // Unreachable indices 5..7 fall back to the reset rate.
    always_comb begin
        rc_max = RC_2;
        case (rate_sel)
            3'd0:    rc_max = RC_0;
            3'd1:    rc_max = RC_1;
            3'd2:    rc_max = RC_2;
            3'd3:    rc_max = RC_3;
            3'd4:    rc_max = RC_4;
            default: rc_max = RC_2;
        endcase
    end

    // >= rather than == so a switch to a faster rate while the counter is
    // already past the new limit steps on the very next cycle.
    assign step = (rate_cnt >= rc_max);

    // Next dot position on a step.
    logic [POS_W-1:0] pos_nxt;
    logic             dir_nxt;
    logic [POS_W-1:0] bounce_end;

    always_comb begin
        pos_nxt    = pos;
        dir_nxt    = dir;
        bounce_end = (mode_sel == MODE_MIRROR) ? POS_HALF : POS_LAST;
        if (mode_sel == MODE_ROTATE) begin
            pos_nxt = (pos == POS_LAST) ? '0 : pos + 1'b1;
        end else if (dir == DIR_LEFT) begin
            if (pos >= bounce_end) begin
                pos_nxt = bounce_end - 1'b1;
                dir_nxt = DIR_RIGHT;
            end else begin
                pos_nxt = pos + 1'b1;
            end
        end else begin
            if (pos == '0) begin
                pos_nxt = POS_W'(1);
                dir_nxt = DIR_LEFT;
            end else begin
                pos_nxt = pos - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rate_sel   <= 3'd2;
            mode_sel   <= MODE_BOUNCE;
            rate_cnt   <= '0;
            pos        <= '0;
            dir        <= DIR_LEFT;
            bright_lvl <= LVL_MAX;
            pwm_cnt    <= '0;
            hist_vld   <= '0;
            for (int k = 0; k < HIST_D; k++) begin
                hist_pos[k] <= '0;
            end
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;

            if (rate_ev) begin
                rate_sel <= (rate_sel >= 3'd4) ? 3'd0 : rate_sel + 3'd1;
            end

            if (bright_ev) begin
                bright_lvl <= (bright_lvl <= LVL_W'(1)) ? LVL_MAX : bright_lvl - 1'b1;
            end

            // A mode change restarts the scan and wins over a coincident step.
            if (mode_ev) begin
                mode_sel <= mode_sel + 2'd1;
                pos      <= '0;
                dir      <= DIR_LEFT;
                rate_cnt <= '0;
                hist_vld <= '0;
            end else if (step) begin
                rate_cnt <= '0;
                pos      <= pos_nxt;
                dir      <= dir_nxt;
                if (HIST_N > 0) begin
                    hist_pos[0] <= pos;
                    hist_vld[0] <= 1'b1;
                    for (int k = 1; k < HIST_N; k++) begin
                        hist_pos[k] <= hist_pos[k-1];
                        hist_vld[k] <= hist_vld[k-1];
                    end
                end
            end else begin
                rate_cnt <= rate_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // LED image: per-position brightness level, then PWM compare.
    // History is scanned oldest first so the most recent (brightest)
    // entry wins when two land on one LED; the head is never overridden.
    // ------------------------------------------------------------------
    logic [OUT_WIDTH-1:0] led_img;
    logic [LVL_W-1:0]     lvl;

    always_comb begin
        led_img = '0;
        lvl     = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            lvl = '0;
            if (POS_W'(i) == pos) begin
                lvl = bright_lvl;
            end else if ((mode_sel == MODE_MIRROR) && (POS_W'(i) == (POS_LAST - pos))) begin
                lvl = bright_lvl;
            end else if (mode_sel == MODE_TRAIL) begin
                for (int k = HIST_N - 1; k >= 0; k--) begin
                    if (hist_vld[k] && (hist_pos[k] == POS_W'(i))) begin
                        lvl = bright_lvl >> (k + 1);
                    end
                end
            end
            led_img[i] = ({1'b0, pwm_cnt} < lvl);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            led <= '0;
        end else begin
            led <= led_img;
        end
    end

endmodule

// File: tb/tb_knight_rider_scanner.sv
// Bench for knight_rider_scanner with an 8-LED, 64 Hz configuration so
// every rate step interval is short (8..128 cycles).

`timescale 1ns/1ps

module tb_knight_rider_scanner;

    localparam int W        = 8;
    localparam int CLK_FREQ = 64;

    localparam int BTN_RATE   = 0;
    localparam int BTN_MODE   = 1;
    localparam int BTN_BRIGHT = 2;

    // ---------------- clock / reset ----------------
    logic         clk         = 1'b0;
    logic         reset       = 1'b0;
    logic         change_rate = 1'b0;
    logic         change_mode = 1'b0;
    logic         brightness  = 1'b0;
    logic [W-1:0] led;
    logic [2:0]   rate_sel;
    logic [1:0]   mode_sel;

    always #5 clk = ~clk;

    knight_rider_scanner #(
        .OUT_WIDTH (W),
        .CLK_FREQ  (CLK_FREQ),
        .CNT_WIDTH (8),
        .PWM_BITS  (3),
        .TRAIL_LEN (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .change_rate (change_rate),
        .change_mode (change_mode),
        .brightness  (brightness),
        .led         (led),
        .rate_sel    (rate_sel),
        .mode_sel    (mode_sel)
    );

    // ---------------- scoreboard ----------------
    // exp_q: expected LED changes, {gap in cycles since previous change, led};
    // gap 0 means the interval is not checked.
    logic [15:0] exp_q[$];

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;
    chk_t chk_q[$];

    int           tests = 0;
    int           fails = 0;
    bit           mon_en = 1'b0;
    int           cyc = 0;
    int           last_cyc = 0;
    logic [W-1:0] last_led = '0;

    initial begin : monitor
        logic [15:0] e;
        chk_t        c;
        int          gap;
        forever begin
            @(negedge clk);
            cyc++;
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                tests++;
                if (c.act !== c.exp) begin
                    fails++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h", c.name, c.act, c.exp);
                end
            end
            if (!mon_en) begin
                last_led = led;
                last_cyc = cyc;
            end else if (led !== last_led) begin
                gap = cyc - last_cyc;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL led_unexpected: got 0x%0h after %0d cycles, expected no change", led, gap);
                end else begin
                    e = exp_q.pop_front();
                    if ((led !== e[W-1:0]) || ((e[15:8] != 8'd0) && (gap != int'(e[15:8])))) begin
                        fails++;
                        $display("FAIL led_step: got 0x%0h after %0d cycles, expected 0x%0h after %0d cycles",
                                 led, gap, e[W-1:0], e[15:8]);
                    end
                end
                last_led = led;
                last_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic push_led(input int gap, input logic [W-1:0] v);
        exp_q.push_back({8'(gap), v});
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            BTN_RATE: change_rate = v;
            BTN_MODE: change_mode = v;
            default:  brightness  = v;
        endcase
    endtask

    // Holds reset low across two edges, checks reset values, releases.
    // On return the next posedge is the first one out of reset.
    task automatic apply_reset();
        mon_en = 1'b0;
        reset  = 1'b0;
        tick(2);
        check("reset_led", 32'(led), 32'h0);
        check("reset_rate_sel", 32'(rate_sel), 32'd2);
        check("reset_mode_sel", 32'(mode_sel), 32'd0);
        reset = 1'b1;
    endtask

    // Clean press: 3 cycles high, 3 low.
    task automatic press(input int which);
        set_btn(which, 1'b1);
        tick(3);
        set_btn(which, 1'b0);
        tick(3);
    endtask

    // Press that also checks the selector is unchanged after the 3rd edge
    // and updated after the 4th edge.
    task automatic press_sel(input int which, input int old_v, input int new_v);
        set_btn(which, 1'b1);
        tick(3);
        if (which == BTN_RATE) check("rate_sel_hold", 32'(rate_sel), 32'(old_v));
        else                   check("mode_sel_hold", 32'(mode_sel), 32'(old_v));
        set_btn(which, 1'b0);
        tick(1);
        if (which == BTN_RATE) check("rate_sel_new", 32'(rate_sel), 32'(new_v));
        else                   check("mode_sel_new", 32'(mode_sel), 32'(new_v));
        tick(2);
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0) begin
            tick(1);
            n++;
            if (n > max_cyc) begin
                $display("FAIL drain_timeout: %0d entries pending after %0d cycles, expected 0", exp_q.size(), n);
                $fatal(1, "scoreboard stalled");
            end
        end
    endtask

    int bit_cnt[W];
    int tot_ones;
    int lit_samples;

    task automatic sample8();
        for (int b = 0; b < W; b++) bit_cnt[b] = 0;
        tot_ones    = 0;
        lit_samples = 0;
        for (int s = 0; s < 8; s++) begin
            for (int b = 0; b < W; b++) begin
                bit_cnt[b] += int'(led[b]);
                tot_ones   += int'(led[b]);
            end
            if (led != '0) lit_samples++;
            tick(1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int n;

        // Single-dot bounce at rate 2 (32 cycles per step).
        apply_reset();
        mon_en = 1'b1;
        push_led(0, 8'h01);
        for (int k = 1; k < 8; k++)   push_led(32, 8'(1 << k));
        for (int k = 6; k >= 0; k--)  push_led(32, 8'(1 << k));
        wait_drain(600);

        // Rate cycling 3,4,0,1 with step intervals 16,8,128,64.
        apply_reset();
        mon_en = 1'b1;
        push_led(0, 8'h01);
        press_sel(BTN_RATE, 2, 3);
        push_led(16, 8'h02);
        push_led(16, 8'h04);
        push_led(16, 8'h08);
        wait_drain(200);
        press_sel(BTN_RATE, 3, 4);
        push_led(8, 8'h10);
        push_led(8, 8'h20);
        push_led(8, 8'h40);
        wait_drain(100);
        press_sel(BTN_RATE, 4, 0);
        push_led(128, 8'h80);
        push_led(128, 8'h40);
        wait_drain(400);
        press_sel(BTN_RATE, 0, 1);
        push_led(64, 8'h20);
        push_led(64, 8'h10);
        wait_drain(200);

        // Glitch between edges is never sampled; a pulse covering one edge is.
        mon_en = 1'b0;
        change_rate = 1'b1;
        #3;
        change_rate = 1'b0;
        tick(6);
        check("glitch_ignored", 32'(rate_sel), 32'd1);
        change_rate = 1'b1;
        tick(1);
        change_rate = 1'b0;
        tick(5);
        check("one_cycle_pulse", 32'(rate_sel), 32'd2);

        // Mode walk: trail, rotate (0x80 -> 0x01), mirror.
        apply_reset();
        press_sel(BTN_MODE, 0, 1);
        press_sel(BTN_MODE, 1, 2);
        check("rotate_restart", 32'(led), 32'h01);
        mon_en = 1'b1;
        for (int k = 1; k < 8; k++) push_led(32, 8'(1 << k));
        push_led(32, 8'h01);
        push_led(32, 8'h02);
        wait_drain(500);
        mon_en = 1'b0;
        press_sel(BTN_MODE, 2, 3);
        check("mirror_restart", 32'(led), 32'h81);
        mon_en = 1'b1;
        push_led(32, 8'h42);
        push_led(32, 8'h24);
        push_led(32, 8'h18);
        push_led(32, 8'h24);
        push_led(32, 8'h42);
        push_led(32, 8'h81);
        wait_drain(400);

        // Brightness and trail.
        mon_en = 1'b0;
        apply_reset();
        press_sel(BTN_MODE, 0, 1);
        n = 0;
        while (led[2] !== 1'b1) begin
            tick(1);
            n++;
            if (n > 200) begin
                $display("FAIL trail_wait: led 0x%0h, expected bit 2 lit within 200 cycles", led);
                $fatal(1, "trail head never reached");
            end
        end
        tick(1);
        sample8();
        check("trail_head_8of8", 32'(bit_cnt[2]), 32'd8);
        check("trail_prev_4of8", 32'(bit_cnt[1]), 32'd4);
        check("trail_prev2_2of8", 32'(bit_cnt[0]), 32'd2);
        check("trail_others_off", 32'(tot_ones - bit_cnt[0] - bit_cnt[1] - bit_cnt[2]), 32'd0);
        for (int p = 0; p < 7; p++) press(BTN_BRIGHT);
        sample8();
        check("bright1_total_on", 32'(tot_ones), 32'd1);
        press(BTN_BRIGHT);
        tick(8);
        sample8();
        check("bright8_lit_samples", 32'(lit_samples), 32'd8);
        check("bright8_head", 32'(bit_cnt[4]), 32'd8);
        check("bright8_prev", 32'(bit_cnt[3]), 32'd4);
        check("bright8_prev2", 32'(bit_cnt[2]), 32'd2);

        // Mode event on the same edge as a step (edge 64 after release).
        apply_reset();
        tick(60);
        change_mode = 1'b1;
        tick(3);
        check("align_mode_before", 32'(mode_sel), 32'd0);
        check("align_led_before", 32'(led), 32'h02);
        change_mode = 1'b0;
        tick(1);
        check("align_mode_after", 32'(mode_sel), 32'd1);
        tick(1);
        check("align_pos_zero", 32'(led), 32'h01);

        // One-cycle reset in the middle of a scan.
        tick(40);
        reset = 1'b0;
        tick(1);
        check("midreset_led", 32'(led), 32'h0);
        check("midreset_rate_sel", 32'(rate_sel), 32'd2);
        check("midreset_mode_sel", 32'(mode_sel), 32'd0);
        reset = 1'b1;
        tick(1);
        check("restart_led", 32'(led), 32'h01);
        push_led(0, 8'h01);
        push_led(32, 8'h02);
        push_led(32, 8'h04);
        mon_en = 1'b1;
        wait_drain(200);

        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/knight_rider_scanner.md
Name: knight_rider_scanner

Overview:
- Parametrised successor to the single-dot Knight Rider LED chaser.
- Drives OUT_WIDTH LEDs with a moving dot in one of four scan modes.
- Uses selectable step rate and PWM brightness, with a fading trail in trail mode.
- Sits directly behind the chip IO pins; all user inputs are asynchronous push-buttons.

Parameters:
- OUT_WIDTH, 8, number of LEDs (>=4, even).
- CLK_FREQ, 6000, clock frequency in Hz; sets the rate divider values.
- CNT_WIDTH, 14, rate counter width; must hold 2*CLK_FREQ-1.
- PWM_BITS, 3, PWM counter width; gives 2^PWM_BITS brightness levels.
- TRAIL_LEN, 3, number of lit positions in trail mode, head included (1..4).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- change_rate  input  1  async button; each rising edge advances the rate.
- change_mode  input  1  async button; each rising edge advances the mode.
- brightness  input  1  async button; each rising edge steps the brightness.
- led  output  OUT_WIDTH  LED drive, registered.
- rate_sel  output  3  current rate index.
- mode_sel  output  2  current mode index.

Behaviour:
- All state is updated on posedge clk. While reset==0, all registers take their reset values.
- Reset values:
  - led=0, rate_sel=2, mode_sel=0, pos=0, dir=LEFT.
  - bright_lvl=2^PWM_BITS, rate counter 0, pwm_cnt 0, trail history cleared, sync registers 0.
- Button inputs:
  - Each button has 2 sync FFs plus 1 edge FF.
  - The event pulse is 1 cycle wide, when the synced value is 1 and the delayed value is 0.
  - The target register updates on the 4th posedge after the input rises (counting the first sampling edge).
  - A button must hold stable for >=2 cycles high and >=2 cycles low to register.
- Rate:
  - rc_max by rate_sel: 0 → 2*CLK_FREQ-1; 1 → CLK_FREQ-1; 2 → CLK_FREQ/2-1; 3 → CLK_FREQ/4-1; 4 → CLK_FREQ/8-1. Integer division.
  - The counter increments each cycle. When counter>=rc_max, step=1 and the counter is set to 0.
  - A rate event sets rate_sel to rate_sel+1, wrapping 4 → 0. Values 5-7 are unreachable; if present, decode them as rate 2.
  - If the rate changes while counter>rc_max, step fires on the next cycle.
- Position update on step:
  - Mode 0 BOUNCE / mode 1 TRAIL:
    - dir LEFT: pos+1. At pos==OUT_WIDTH-1 the step gives pos=OUT_WIDTH-2 and dir=RIGHT.
    - dir RIGHT: mirrored; at pos==0 the step gives pos=1 and dir=LEFT.
    - Period is 2*(OUT_WIDTH-1) steps.
  - Mode 2 ROTATE: pos+1, with OUT_WIDTH-1 wrapping to 0. dir is ignored.
  - Mode 3 MIRROR:
    - pos bounces over 0..OUT_WIDTH/2-1 using the bounce rule with end OUT_WIDTH/2-1.
    - Two dots are lit, at pos and OUT_WIDTH-1-pos.
- Mode event:
  - mode_sel <= mode_sel+1, wrapping 3 → 0.
  - Same cycle: pos=0, dir=LEFT, rate counter=0, trail history cleared.
  - A mode event overrides a step in the same cycle.
  - Rate and brightness events in the same cycle are also applied.
- Trail (mode 1 only):
  - A history of the last TRAIL_LEN-1 head positions shifts on each step.
  - History entry k (k=1 is most recent) is shown at level bright_lvl>>k.
  - A history entry equal to the current pos is not double-driven; the head level wins.
  - Cleared history entries light nothing.
- Brightness:
  - bright_lvl ranges 1..2^PWM_BITS, using PWM_BITS+1 bits.
  - An event decrements it; 1 wraps to 2^PWM_BITS.
- PWM:
  - pwm_cnt is free-running, PWM_BITS wide, and wraps.
  - A lit position with level L drives 1 when pwm_cnt < L. L=2^PWM_BITS means always on; L=0 means off.
- led register:
  - led is computed from the current state and registered.
  - The LED image lags the state by exactly 1 cycle.
  - After reset deasserts, led[0] is 1 from the first cycle on (full brightness).

Test Plan:
- Single-dot bounce:
  - Setup: OUT_WIDTH=8, CLK_FREQ=64, default brightness. Release reset.
  - Required: led steps every 32 cycles through 0x01,0x02,…,0x80,0x40,…,0x01. No other bits are ever set.
- Rate cycling:
  - Stimulus: pulse change_rate 4 times.
  - Required: rate_sel goes 3,4,0,1. The step interval measures 16, 8, 128, 64 cycles.
  - Required: a 1-cycle pulse is also shown to be ignored or captured, consistent with the sync rule.
- Mode walk:
  - Stimulus: pulse change_mode once (mode 1) and observe trail. Then mode 2: pos 7 → 0, led 0x80 → 0x01. Then mode 3: led 0x81,0x42,0x24,0x18,0x24.
  - Required: each mode event restarts at pos 0.
- Brightness and trail:
  - Stimulus: mode 1, bright_lvl=8.
  - Required: over 8 cycles, head on 8/8, previous position 4/8, the one before 2/8.
  - Stimulus: step brightness to 1.
  - Required: head 1/8 and trail off. One more step gives 8.
- Simultaneous/reset:
  - Stimulus: align a change_mode event with a step. Required: mode changes and pos=0.
  - Stimulus: assert reset mid-scan for 1 cycle. Required: all outputs return to reset values on that edge, and the scan restarts at 0x01 with rate 2.
